maquina_cafe_param: RTL and testbench

MAQUINA_CAFE_PARAM -- requirements
Module: maquina_cafe_param

---
 rtl/maquina_pkg.sv | 53 +++++
 rtl/hex7seg.sv | 27 ++
 rtl/maquina_cafe_param.sv | 225 ++++++++++++++++++++++
 tb/tb_maquina_cafe_param.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// Shared definitions for the coffee machine: FSM states, ingredient bit
// positions inside the dispense mask, seven-segment glyphs and the
// helpers that split a 0..99 value into decimal digits.
package maquina_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    // Dispense order is the bit order: lowest set bit runs first.
    localparam int N_ING      = 5;
    localparam int ING_AGUA   = 0;
    localparam int ING_CAFE   = 1;
    localparam int ING_LECHE  = 2;
    localparam int ING_CHOCO  = 3;
    localparam int ING_AZUCAR = 4;

    // Active-low segments, bit6 = g ... bit0 = a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Tens digit of a value in 0..99, by comparison instead of a divider.
    function automatic logic [3:0] bcd_tens(input logic [6:0] value);
        logic [3:0] tens;
        tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (value >= 7'(10 * i)) begin
                tens = 4'(i);
            end
        end
        return tens;
    endfunction

    // Units digit: the remainder is below 10, so 4-bit modular
    // subtraction of the low nibble gives the exact result.
    function automatic logic [3:0] bcd_units(input logic [6:0] value);
        logic [3:0] tens;
        tens = bcd_tens(value);
        return value[3:0] - (tens * 4'd10);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// One decimal digit to an active-low seven-segment pattern; codes above 9
// blank the display.
module hex7seg
    import maquina_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Glyph lookup.
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/maquina_cafe_param.sv
// Parameterised coffee vending machine. Coins build credit, a one-hot
// selection buys a drink whose recipe mask drives the ingredient valves in
// fixed order, and surplus money leaves through a one-cycle change pulse.
// The configuration must keep MAX_CREDIT + COIN_C_VAL + COIN_Q_VAL below
// 2**CREDIT_W so no credit arithmetic wraps.
module maquina_cafe_param
    import maquina_pkg::*;
#(
    parameter int         N_DRINKS    = 5,
    parameter int         CREDIT_W    = 8,
    parameter int         MAX_CREDIT  = 99,
    parameter int         COIN_C_VAL  = 10,
    parameter int         COIN_Q_VAL  = 25,
    parameter int         STEP_CYCLES = 4,
    parameter int         PRICE  [N_DRINKS] = '{30, 45, 50, 55, 35},
    // Mask bits are {choco, leche, cafe, agua}.
    parameter logic [3:0] RECIPE [N_DRINKS] = '{4'b0011, 4'b0111, 4'b1111, 4'b1100, 4'b1001}
) (
    input  logic                clk_50Mhz,
    input  logic                rst,
    input  logic                coin_c,
    input  logic                coin_q,
    input  logic [N_DRINKS-1:0] sel,
    input  logic                sugar,
    input  logic                cancel,
    output logic                agua,
    output logic                cafe,
    output logic                leche,
    output logic                choco,
    output logic                azucar,
    output logic                bebida_lista,
    output logic                falta,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    // Previous-cycle input levels for rising-edge detection.
    logic                coin_c_d;
    logic                coin_q_d;
    logic                cancel_d;
    logic [N_DRINKS-1:0] sel_d;

    logic                coin_c_ev;
    logic                coin_q_ev;
    logic                cancel_ev;
    logic [N_DRINKS-1:0] sel_ev;
    logic                sel_valid;
    logic [CREDIT_W-1:0] sel_price;
    logic [3:0]          sel_recipe;
    logic [CREDIT_W-1:0] coin_sum;
    logic [CREDIT_W-1:0] credit_plus;

    state_t              state;
    logic [N_ING-1:0]    valves;    // one-hot or zero
    logic [N_ING-1:0]    pending;   // ingredients still to dispense
    logic [CNT_W-1:0]    step_cnt;  // remaining cycles of the open valve

    logic [6:0]          disp;
    logic [3:0]          tens;
    logic [3:0]          units;

    // Edge-detect history, cleared by reset so a level held through reset
    // counts as a fresh event.
    always_ff @(posedge clk_50Mhz) begin
        // NOTE: registers take <= so every reader in this clock sees the
        // pre-edge value regardless of statement order.
        if (rst) begin
            coin_c_d <= 1'b0;
            coin_q_d <= 1'b0;
            cancel_d <= 1'b0;
            sel_d    <= '0;
        end else begin
            coin_c_d <= coin_c;
            coin_q_d <= coin_q;
            cancel_d <= cancel;
            sel_d    <= sel;
        end
    end

    // Event decode, same-cycle coin total and selected drink lookup.
    always_comb begin
        // NOTE: every output gets a default before the branches below, so
        // no path leaves a variable unassigned and no latch is inferred.
        sel_price  = '0;
        sel_recipe = '0;
        coin_c_ev  = coin_c & ~coin_c_d;
        coin_q_ev  = coin_q & ~coin_q_d;
        cancel_ev  = cancel & ~cancel_d;
        sel_ev     = sel & ~sel_d;
        sel_valid  = $onehot(sel_ev);
        coin_sum   = (coin_c_ev ? CREDIT_W'(COIN_C_VAL) : '0)
                   + (coin_q_ev ? CREDIT_W'(COIN_Q_VAL) : '0);
        credit_plus = credit + coin_sum;
        for (int i = 0; i < N_DRINKS; i++) begin
            if (sel_ev[i]) begin
                sel_price  = CREDIT_W'(PRICE[i]);
                sel_recipe = RECIPE[i];
            end
        end
    end

    // Main FSM with registered credit, valves and pulse outputs.
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state        <= ST_IDLE;
            credit       <= '0;
            valves       <= '0;
            pending      <= '0;
            step_cnt     <= '0;
            bebida_lista <= 1'b0;
            falta        <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
        end else begin
            bebida_lista <= 1'b0;
            falta        <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;

            case (state)
                ST_IDLE: begin
                    if (cancel_ev) begin
                        credit <= '0;
                        if (credit_plus != '0) begin
                            change_valid <= 1'b1;
                            change_amt   <= credit_plus;
                        end
                    end else if (sel_valid) begin
                        if (credit < sel_price) begin
                            // Refused: keep credit, hand back any coins
                            // that arrived in the same cycle.
                            falta <= 1'b1;
                            if (coin_sum != '0) begin
                                change_valid <= 1'b1;
                                change_amt   <= coin_sum;
                            end
                        end else begin
                            credit <= '0;
                            if (credit_plus != sel_price) begin
                                change_valid <= 1'b1;
                                change_amt   <= credit_plus - sel_price;
                            end
                            // Sugar is latched as the last mask bit.
                            pending  <= {sugar, sel_recipe};
                            step_cnt <= '0;
                            valves   <= '0;
                            if (!sugar && sel_recipe == 4'b0000) begin
                                state        <= ST_DONE;
                                bebida_lista <= 1'b1;
                            end else begin
                                state <= ST_DISPENSE;
                            end
                        end
                    end else if (coin_sum != '0) begin
                        if (credit_plus > CREDIT_W'(MAX_CREDIT)) begin
                            change_valid <= 1'b1;
                            change_amt   <= coin_sum;
                        end else begin
                            credit <= credit_plus;
                        end
                    end
                end

                ST_DISPENSE: begin
                    if (step_cnt != '0) begin
                        step_cnt <= step_cnt - CNT_W'(1);
                    end else if (pending != '0) begin
                        // Open the lowest pending ingredient, retire it.
                        valves   <= pending & -pending;
                        pending  <= pending & (pending - N_ING'(1));
                        step_cnt <= CNT_W'(STEP_CYCLES - 1);
                    end else begin
                        valves       <= '0;
                        state        <= ST_DONE;
                        bebida_lista <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // While busy, coins bounce straight back; sel and cancel are
            // not looked at.
            if (state != ST_IDLE && coin_sum != '0) begin
                change_valid <= 1'b1;
                change_amt   <= coin_sum;
            end
        end
    end

    assign agua   = valves[ING_AGUA];
    assign cafe   = valves[ING_CAFE];
    assign leche  = valves[ING_LECHE];
    assign choco  = valves[ING_CHOCO];
    assign azucar = valves[ING_AZUCAR];

    // Display value clamped to two digits and split into tens/units.
    always_comb begin
        disp  = (credit > CREDIT_W'(99)) ? 7'd99 : 7'(credit);
        tens  = bcd_tens(disp);
        units = bcd_units(disp);
    end

    hex7seg u_hex_tens (
        .digit (tens),
        .seg   (hex1)
    );

    hex7seg u_hex_units (
        .digit (units),
        .seg   (hex2)
    );

endmodule

// File: tb/tb_maquina_cafe_param.sv
// Bench for maquina_cafe_param: directed scenarios followed by random
// traffic, every cycle compared against a schedule-based reference model.
module tb_maquina_cafe_param;

    localparam int ND       = 5;
    localparam int CW       = 8;
    localparam int STEP     = 4;
    localparam int MAXC     = 99;
    localparam int CV       = 10;
    localparam int QV       = 25;
    localparam int TAG_DONE = 8;
    localparam int TAG_NOP  = 9;

    int         price_tab  [ND] = '{30, 45, 50, 55, 35};
    logic [3:0] recipe_tab [ND] = '{4'b0011, 4'b0111, 4'b1111, 4'b1100, 4'b1001};

    logic          clk_50Mhz = 1'b0;
    logic          rst       = 1'b1;
    logic          coin_c    = 1'b0;
    logic          coin_q    = 1'b0;
    logic [ND-1:0] sel       = '0;
    logic          sugar     = 1'b0;
    logic          cancel    = 1'b0;
    logic          agua, cafe, leche, choco, azucar;
    logic          bebida_lista, falta, change_valid;
    logic [CW-1:0] change_amt, credit;
    logic [6:0]    hex1, hex2;

    maquina_cafe_param dut (
        .clk_50Mhz    (clk_50Mhz),
        .rst          (rst),
        .coin_c       (coin_c),
        .coin_q       (coin_q),
        .sel          (sel),
        .sugar        (sugar),
        .cancel       (cancel),
        .agua         (agua),
        .cafe         (cafe),
        .leche        (leche),
        .choco        (choco),
        .azucar       (azucar),
        .bebida_lista (bebida_lista),
        .falta        (falta),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .hex1         (hex1),
        .hex2         (hex2)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int       m_credit = 0;
    bit       m_cc = 0, m_cq = 0, m_cn = 0;
    bit [4:0] m_sel = '0;
    int       sched[$];             // per-cycle plan while busy
    bit       e_cv, e_falta, e_beb;
    int       e_amt;
    bit [4:0] e_valves;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic give_change(input int amt);
        if (amt > 0) begin
            e_cv  = 1'b1;
            e_amt = amt;
        end
    endtask

    // Applies the machine rules to the inputs present at this clock edge.
    task automatic model_edge();
        bit       ce, qe, ne;
        bit [4:0] se;
        int       sum, idx, e;
        e_cv = 0; e_amt = 0; e_falta = 0; e_beb = 0; e_valves = '0;
        if (rst) begin
            m_credit = 0;
            sched.delete();
            m_cc = 0; m_cq = 0; m_cn = 0; m_sel = '0;
        end else begin
            ce  = coin_c && !m_cc;
            qe  = coin_q && !m_cq;
            ne  = cancel && !m_cn;
            se  = sel & ~m_sel;
            sum = (ce ? CV : 0) + (qe ? QV : 0);
            if (sched.size() > 0) begin
                e = sched.pop_front();
                if (e == TAG_DONE) e_beb = 1'b1;
                else if (e != TAG_NOP) e_valves = 5'(1 << e);
                give_change(sum);
            end else if (ne) begin
                give_change(m_credit + sum);
                m_credit = 0;
            end else if ($countones(se) == 1) begin
                idx = 0;
                for (int i = 0; i < ND; i++) if (se[i]) idx = i;
                if (m_credit < price_tab[idx]) begin
                    e_falta = 1'b1;
                    give_change(sum);
                end else begin
                    give_change(m_credit - price_tab[idx] + sum);
                    m_credit = 0;
                    for (int ing = 0; ing < 4; ing++)
                        if (recipe_tab[idx][ing])
                            for (int k = 0; k < STEP; k++) sched.push_back(ing);
                    if (sugar)
                        for (int k = 0; k < STEP; k++) sched.push_back(4);
                    if (sched.size() == 0) begin
                        e_beb = 1'b1;
                        sched.push_back(TAG_NOP);
                    end else begin
                        sched.push_back(TAG_DONE);
                        sched.push_back(TAG_NOP);
                    end
                end
            end else if (sum > 0) begin
                if (m_credit + sum > MAXC) give_change(sum);
                else m_credit = m_credit + sum;
            end
            m_cc = coin_c; m_cq = coin_q; m_cn = cancel; m_sel = sel;
        end
    endtask

    task automatic compare_all();
        int shown;
        shown = (m_credit > 99) ? 99 : m_credit;
        check("credit", credit, m_credit);
        check("change", {change_valid, change_amt}, {e_cv, 8'(e_amt)});
        check("falta", falta, e_falta);
        check("bebida_lista", bebida_lista, e_beb);
        check("valves", {azucar, choco, leche, cafe, agua}, e_valves);
        check("hex", {hex1, hex2}, {seg_of(shown / 10), seg_of(shown % 10)});
    endtask

    task automatic tick();
        @(posedge clk_50Mhz);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic apply(input bit cc, input bit cq, input bit cn,
                         input logic [ND-1:0] s, input bit sg);
        coin_c = cc; coin_q = cq; cancel = cn; sel = s; sugar = sg;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, '0, 0);
    endtask

    int n_agua, n_cafe, n_azucar, n_other, beb_at, beb_seen;

    initial begin
        // Reset state.
        rst = 1'b1;
        idle(2);
        check("rst_hex1", hex1, 7'b1000000);
        check("rst_hex2", hex2, 7'b1000000);
        check("rst_credit", credit, 0);
        rst = 1'b0;
        idle(1);

        // One coin_c shows 10 on the display.
        apply(1, 0, 0, '0, 0);
        check("c_credit", credit, 10);
        check("c_hex1", hex1, 7'b1111001);
        check("c_hex2", hex2, 7'b1000000);
        idle(1);
        apply(0, 0, 1, '0, 0);
        check("cancel10", {change_valid, change_amt}, {1'b1, 8'd10});
        idle(1);

        // Two quarters, drink 0 with sugar: timing of the valve sequence.
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 0, 0, 5'b00001, 1);
        check("accept_change", {change_valid, change_amt}, {1'b1, 8'd20});
        check("accept_credit", credit, 0);
        n_agua = 0; n_cafe = 0; n_azucar = 0; n_other = 0; beb_at = -1;
        for (int i = 1; i <= 16; i++) begin
            apply(0, 0, 0, '0, 0);
            if (agua) n_agua++;
            if (cafe) n_cafe++;
            if (azucar) n_azucar++;
            if (leche || choco) n_other++;
            if (bebida_lista) beb_at = i;
        end
        check("seq_agua", n_agua, 4);
        check("seq_cafe", n_cafe, 4);
        check("seq_azucar", n_azucar, 4);
        check("seq_other", n_other, 0);
        check("seq_bebida_cycle", beb_at, 13);

        // Overflowing coin is rejected, then cancel refunds everything.
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 1, 0, '0, 0); idle(1);
        apply(1, 0, 0, '0, 0); idle(1);
        check("credit85", credit, 85);
        apply(0, 1, 0, '0, 0);
        check("reject_change", {change_valid, change_amt}, {1'b1, 8'd25});
        check("reject_credit", credit, 85);
        idle(1);
        apply(0, 0, 1, '0, 0);
        check("cancel85", {change_valid, change_amt}, {1'b1, 8'd85});
        check("cancel_credit", credit, 0);
        idle(1);

        // Insufficient credit, then a two-hot selection.
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 0, 0, 5'b00010, 0);
        check("falta_pulse", falta, 1);
        check("falta_credit", credit, 25);
        idle(1);
        apply(0, 0, 0, 5'b00011, 0);
        check("twohot_falta", falta, 0);
        check("twohot_credit", credit, 25);
        check("twohot_valves", {azucar, choco, leche, cafe, agua}, 0);
        idle(1);
        apply(0, 0, 1, '0, 0);
        idle(1);

        // Coin during dispense is bounced; valves keep running.
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 0, 0, 5'b00001, 0);
        idle(2);
        apply(1, 0, 0, '0, 0);
        check("busy_coin_change", {change_valid, change_amt}, {1'b1, 8'd10});
        check("busy_coin_agua", agua, 1);
        check("busy_coin_credit", credit, 0);
        idle(12);

        // Reset in the middle of a later dispense.
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 1, 0, '0, 0); idle(1);
        apply(0, 0, 0, 5'b00001, 0);
        idle(3);
        rst = 1'b1;
        idle(1);
        check("midrst_valves", {azucar, choco, leche, cafe, agua}, 0);
        check("midrst_bebida", bebida_lista, 0);
        rst = 1'b0;
        beb_seen = 0;
        for (int i = 0; i < 15; i++) begin
            apply(0, 0, 0, '0, 0);
            if (bebida_lista) beb_seen++;
        end
        check("midrst_no_bebida", beb_seen, 0);

        // Coins in the same cycle as an accepted selection.
        apply(1, 0, 0, '0, 0); idle(1);
        apply(1, 0, 0, '0, 0); idle(1);
        apply(1, 0, 0, '0, 0); idle(1);
        check("credit30", credit, 30);
        apply(1, 1, 0, 5'b00001, 0);
        check("samecyc_change", {change_valid, change_amt}, {1'b1, 8'd35});
        check("samecyc_credit", credit, 0);
        idle(16);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [ND-1:0] s;
            int            pick;
            s    = '0;
            pick = int'($urandom_range(0, 9));
            if (pick < 3) s = 5'(1 << $urandom_range(0, 4));
            else if (pick == 3) s = 5'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            apply(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 15) == 0), s, 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
